// File: rtl/stopwatch_core.sv
// ---------------------------------------------------------------------------
// stopwatch_core
// MM:SS stopwatch with pause/run toggle from a raw push button, an adjust
// mode that bumps the selected field at the adjust rate, and a synchronous
// clear. All timing comes from one-cycle tick pulses generated elsewhere.
//
// Parameters
//   SYNC_STAGES  flops in the pause_btn synchronizer (legal range 2..4)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   tick_1hz   count pulse (RUN)
//   tick_2hz   blink pulse (ADJUST)
//   tick_adj   adjust-rate pulse (ADJUST)
//   pause_btn  raw asynchronous button, high = pressed
//   adj        1 = adjust mode requested (synchronous level)
//   sel        0 = adjust minutes, 1 = adjust seconds (synchronous level)
//   clear      1 = zero the time this edge (synchronous level)
//   min_tens, min_ones, sec_tens, sec_ones   registered BCD digits
//   running    registered, 1 only while in RUN
//   blink      registered blanking phase for the selected field in ADJUST
// ---------------------------------------------------------------------------
module stopwatch_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_adj,
  input  logic       pause_btn,
  input  logic       adj,
  input  logic       sel,
  input  logic       clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blink
);

  typedef enum logic [1:0] {
    ST_PAUSE  = 2'd0,
    ST_RUN    = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_running;
  logic                   r_blink;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  logic [3:0]             r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;

  logic                   w_pause_pulse;
  logic                   w_sec_wrap;
  logic [7:0]             w_sec_next;
  logic [7:0]             w_min_next;

  // Two-digit BCD increment modulo 60 (59 -> 00).
  function automatic logic [7:0] bcd_inc60(input logic [3:0] tens,
                                           input logic [3:0] ones);
    if (ones != 4'd9)      return {tens, ones + 4'd1};
    else if (tens != 4'd5) return {tens + 4'd1, 4'd0};
    else                   return 8'h00;
  endfunction

  // -------------------------------------------------------------------------
  // Button synchronizer and rising-edge detector
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, which is what makes the
  // shift chain a chain rather than a single wire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], pause_btn};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // One cycle per press, however long the button is held.
  assign w_pause_pulse = r_sync[SYNC_STAGES-1] & ~r_sync_prev;

  // -------------------------------------------------------------------------
  // Mode FSM with registered running/blink
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_PAUSE;
      r_running <= 1'b0;
      r_blink   <= 1'b0;
    end else if (adj) begin
      // Adjust request wins over everything; a press here is dropped.
      r_state   <= ST_ADJUST;
      r_running <= 1'b0;
      // Only toggle once already in ADJUST, so blink starts from 0 on entry.
      if (r_state == ST_ADJUST && tick_2hz) r_blink <= ~r_blink;
    end else begin
      r_blink <= 1'b0;
      case (r_state)
        ST_PAUSE: begin
          if (w_pause_pulse) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_pause_pulse) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_PAUSE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Time digits. Ticks act on the state held before this edge.
  // -------------------------------------------------------------------------
  assign w_sec_next = bcd_inc60(r_sec_tens, r_sec_ones);
  assign w_min_next = bcd_inc60(r_min_tens, r_min_ones);
  assign w_sec_wrap = (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_min_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_sec_ones <= 4'd0;
    end else if (clear) begin
      r_min_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_sec_ones <= 4'd0;
    end else if (r_state == ST_RUN && tick_1hz) begin
      {r_sec_tens, r_sec_ones} <= w_sec_next;
      if (w_sec_wrap) {r_min_tens, r_min_ones} <= w_min_next;
    end else if (r_state == ST_ADJUST && tick_adj) begin
      // Field-local wrap: no carry between minutes and seconds here.
      if (sel) {r_sec_tens, r_sec_ones} <= w_sec_next;
      else     {r_min_tens, r_min_ones} <= w_min_next;
    end
  end

  assign min_tens = r_min_tens;
  assign min_ones = r_min_ones;
  assign sec_tens = r_sec_tens;
  assign sec_ones = r_sec_ones;
  assign running  = r_running;
  assign blink    = r_blink;

endmodule
